// File: rtl/load_store_unit_pkg.sv
// Opcode and funct3 encodings shared with the address generator, plus the
// lane helpers that turn an access size and byte offset into strobes and data.
package load_store_unit_pkg;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned sizes exist only for loads.
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: funct3_legal = 1'b1;
      F3_BU, F3_HU:     funct3_legal = !is_store;
      default:          funct3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [31:0] address, input logic [1:0] size);
    case (size)
      2'b01:   is_misaligned = address[0];
      2'b10:   is_misaligned = |address[1:0];
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] natural_align(input logic [31:0] address, input logic [1:0] size);
    case (size)
      2'b01:   natural_align = {address[31:1], 1'b0};
      2'b10:   natural_align = {address[31:2], 2'b00};
      default: natural_align = address;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      2'b00:   lane_mask = 4'b0001 << offset;
      2'b01:   lane_mask = 4'b0011 << offset;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   lane_wdata = {4{data[7:0]}};
      2'b01:   lane_wdata = {2{data[15:0]}};
      default: lane_wdata = data;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_aligner.sv
// Combinational load path: shifts the addressed lane down to bit 0 and
// sign- or zero-extends it according to the load size.
module load_data_aligner
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {24'd0, shifted[7:0]};
      F3_HU:   data = {16'd0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, request/grant then rvalid.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of truncating.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        ready,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT_RESP, DONE} state_t;

  state_t      state;
  logic        is_store_q;
  logic        skip_q;
  logic        trap_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;

  logic        is_load;
  logic        is_store;
  logic        legal;
  logic        trap;
  logic [31:0] aligned_addr;
  logic [31:0] aligned_data;

  assign is_load      = (opcode == OPCODE_LOAD);
  assign is_store     = (opcode == OPCODE_STORE);
  assign legal        = funct3_legal(is_store, funct3);
  assign trap         = TRAP_EN & legal & is_misaligned(address, funct3[1:0]);
  assign aligned_addr = natural_align(address, funct3[1:0]);
  assign ready        = (state == IDLE);

  load_data_aligner u_aligner (
    .rdata  (mem_rdata),
    .offset (offset_q),
    .funct3 (funct3_q),
    .data   (aligned_data)
  );

  // Illegal and trapped accesses still pass through REQUEST, but with mem_req low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      done       <= 1'b0;
      misaligned <= 1'b0;
      load_data  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_mask   <= '0;
      is_store_q <= 1'b0;
      skip_q     <= 1'b0;
      trap_q     <= 1'b0;
      funct3_q   <= '0;
      offset_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid && (is_load || is_store)) begin
            is_store_q <= is_store;
            funct3_q   <= funct3;
            offset_q   <= aligned_addr[1:0];
            skip_q     <= !legal || trap;
            trap_q     <= trap;
            mem_req    <= legal && !trap;
            mem_we     <= is_store && legal && !trap;
            mem_addr   <= {aligned_addr[31:2], 2'b00};
            mem_wdata  <= lane_wdata(funct3[1:0], store_data);
            mem_mask   <= lane_mask(funct3[1:0], aligned_addr[1:0]);
            state      <= REQUEST;
          end
        end
        REQUEST: begin
          if (skip_q) begin
            done       <= 1'b1;
            misaligned <= trap_q;
            if (!trap_q) load_data <= '0;
            state      <= DONE;
          end else if (mem_gnt) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (is_store_q) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          if (mem_rvalid) begin
            load_data <= aligned_data;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done       <= 1'b0;
          misaligned <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model predicts each
// request and completion, and a per-cycle compare process checks the DUT against it.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] store_data;
  logic        ready;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  load_store_unit dut (
    .clk        (clk),
    .reset      (reset),
    .valid      (valid),
    .opcode     (opcode),
    .funct3     (funct3),
    .address    (address),
    .store_data (store_data),
    .ready      (ready),
    .done       (done),
    .load_data  (load_data),
    .misaligned (misaligned),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_mask   (mem_mask),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          exp_access, exp_we, exp_mis;
  logic [31:0] exp_addr, exp_wdata, exp_load;
  logic [3:0]  exp_mask;
  int          exp_latency, exp_req_cycles;

  logic [31:0] model_hold = '0;
  bit          in_flight = 1'b0;
  int          accept_cycle = -1;
  int          req_count = 0;
  int          done_req_count = 0;
  int          done_count = 0;
  int          cyc = 0;
  logic [31:0] last_req_addr = '0;
  logic [31:0] last_req_wdata = '0;
  logic [3:0]  last_req_mask = '0;
  logic        last_req_we = 1'b0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Predicts the whole transaction from the architectural rules alone.
  task automatic compute_expect(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] sd, input logic [31:0] rdata,
                                input int gnt_delay, input int rv_delay);
    bit     st, legal, mis;
    int     size;
    longint a, off, val, lim;
    st = (op == OPCODE_STORE);
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default:        size = 0;
    endcase
    legal = (size != 0) && !(st && f3[2]);
    a = longint'({32'd0, addr});
    mis = (size > 1) && ((a % size) != 0);
    exp_access = 0; exp_we = 0; exp_mis = 0;
    exp_addr = '0; exp_mask = '0; exp_wdata = '0;
    exp_req_cycles = 0; exp_latency = 2; exp_load = model_hold;
    if (!legal) begin
      exp_load = '0;
    end else if (TRAP_EN && mis) begin
      exp_mis = 1;
    end else begin
      a = a - (a % size);
      off = a % 4;
      exp_access = 1;
      exp_we = st;
      exp_addr = 32'(a - off);
      exp_mask = 4'(((1 << size) - 1) << off);
      exp_req_cycles = gnt_delay + 1;
      if (st) begin
        exp_latency = gnt_delay + 2;
        exp_wdata = (size == 1) ? {4{sd[7:0]}} : (size == 2) ? {2{sd[15:0]}} : sd;
      end else begin
        exp_latency = gnt_delay + rv_delay + 3;
        lim = longint'(1) << (8 * size);
        val = ({32'd0, rdata} >> (8 * off)) % lim;
        if (!f3[2] && size < 4 && val >= lim / 2) val = val - lim;
        exp_load = 32'(val);
      end
    end
  endtask

  // Compare process: samples 1 ns after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!reset) begin
        in_flight = 0;
        model_hold = '0;
        accept_cycle = -1;
        check_output("rst_ready", 32'(ready), 32'd1);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_mem_req", 32'(mem_req), 32'd0);
        check_output("rst_mem_we", 32'(mem_we), 32'd0);
        check_output("rst_misaligned", 32'(misaligned), 32'd0);
        check_output("rst_mem_mask", 32'(mem_mask), 32'd0);
        check_output("rst_mem_addr", mem_addr, 32'd0);
        check_output("rst_mem_wdata", mem_wdata, 32'd0);
        check_output("rst_load_data", load_data, 32'd0);
      end else begin
        if (accept_cycle >= 0 && cyc == accept_cycle + 1) begin
          in_flight = 1;
          req_count = 0;
        end
        check_output("ready", 32'(ready), 32'(!in_flight));
        if (mem_req) begin
          req_count++;
          check_output("req_allowed", 32'(in_flight && exp_access), 32'd1);
          check_output("mem_addr", mem_addr, exp_addr);
          check_output("mem_mask", 32'(mem_mask), 32'(exp_mask));
          check_output("mem_we", 32'(mem_we), 32'(exp_we));
          if (exp_we) check_output("mem_wdata", mem_wdata, exp_wdata);
          last_req_addr = mem_addr;
          last_req_mask = mem_mask;
          last_req_wdata = mem_wdata;
          last_req_we = mem_we;
        end
        if (done) begin
          check_output("done_expected", 32'(in_flight), 32'd1);
          check_output("latency", 32'(cyc - accept_cycle), 32'(exp_latency));
          check_output("load_data", load_data, exp_load);
          check_output("misaligned", 32'(misaligned), 32'(exp_mis));
          check_output("req_cycles", 32'(req_count), 32'(exp_req_cycles));
          done_req_count = req_count;
          model_hold = exp_load;
          in_flight = 0;
          accept_cycle = -1;
          done_count++;
        end else begin
          check_output("load_data_hold", load_data, model_hold);
        end
      end
    end
  end

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_count < target && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_output("done_seen", 32'(done_count >= target), 32'd1);
    @(negedge clk);
  endtask

  // Issues one access at a falling edge and plays the memory side of the handshake.
  task automatic apply_stimulus(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] sd, input logic [31:0] rdata,
                                input int gnt_delay, input int rv_delay, input bit poke);
    int target;
    compute_expect(op, f3, addr, sd, rdata, gnt_delay, rv_delay);
    target = done_count + 1;
    valid = 1; opcode = op; funct3 = f3; address = addr; store_data = sd;
    accept_cycle = cyc;
    @(negedge clk);
    valid = 0;
    if (exp_access) begin
      for (int i = 0; i <= gnt_delay; i++) begin
        mem_gnt = (i == gnt_delay);
        if (poke) begin
          valid = 1; opcode = OPCODE_STORE; funct3 = F3_W;
          address = 32'hFFFF_FFF0; store_data = 32'h5555_AAAA;
          mem_rvalid = 1; mem_rdata = 32'hDEAD_DEAD;
        end
        @(negedge clk);
      end
      mem_gnt = 0; valid = 0; mem_rvalid = 0;
      if (op == OPCODE_LOAD) begin
        for (int i = 0; i <= rv_delay; i++) begin
          mem_rvalid = (i == rv_delay);
          mem_rdata = rdata;
          @(negedge clk);
        end
        mem_rvalid = 0;
      end
    end
    wait_done(target);
  endtask

  task automatic reset_test();
    compute_expect(OPCODE_STORE, F3_W, 32'h0000_0040, 32'h1111_2222, 32'd0, 3, 0);
    valid = 1; opcode = OPCODE_STORE; funct3 = F3_W; address = 32'h40; store_data = 32'h1111_2222;
    accept_cycle = cyc;
    @(negedge clk);
    valid = 0;
    @(negedge clk);
    reset = 0;
    #1;
    check_output("async_mem_req_drop", 32'(mem_req), 32'd0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);

    compute_expect(OPCODE_LOAD, F3_W, 32'h0000_0010, 32'd0, 32'h1234_5678, 0, 0);
    valid = 1; opcode = OPCODE_LOAD; funct3 = F3_W; address = 32'h10;
    accept_cycle = cyc;
    @(negedge clk);
    valid = 0; mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    reset = 0;
    #1;
    check_output("async_ready", 32'(ready), 32'd1);
    check_output("async_load_data", load_data, 32'd0);
    @(negedge clk);
    reset = 1; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid = 0;
    repeat (3) @(negedge clk);
    check_output("post_reset_load_data", load_data, 32'd0);
  endtask

  initial begin
    reset = 0; valid = 0; opcode = '0; funct3 = '0; address = '0; store_data = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);

    apply_stimulus(OPCODE_LOAD, F3_B, 32'h0000_1003, 32'd0, 32'h80FF_FFFF, 0, 0, 0);
    check_output("lb_literal", load_data, 32'hFFFF_FF80);

    apply_stimulus(OPCODE_STORE, F3_H, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 0, 0, 0);
    check_output("sh_addr_literal", last_req_addr, 32'h0000_2000);
    check_output("sh_mask_literal", 32'(last_req_mask), 32'h0000_000C);
    check_output("sh_wdata_literal", last_req_wdata, 32'hABCD_ABCD);
    check_output("sh_we_literal", 32'(last_req_we), 32'd1);

    apply_stimulus(OPCODE_LOAD, F3_HU, 32'h0000_0000, 32'd0, 32'hBEEF_8001, 5, 1, 1);
    check_output("lhu_literal", load_data, 32'h0000_8001);
    check_output("lhu_req_cycles", 32'(done_req_count), 32'd6);

    apply_stimulus(OPCODE_LOAD, F3_W, 32'h0000_1001, 32'd0, 32'hCAFE_F00D, 0, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check_output("lw_trap_hold_literal", load_data, 32'h0000_8001);
`else
    check_output("lw_trunc_literal", load_data, 32'hCAFE_F00D);
    check_output("lw_trunc_addr_literal", last_req_addr, 32'h0000_1000);
`endif

    apply_stimulus(OPCODE_STORE, F3_B, 32'h0000_0005, 32'h0000_00A5, 32'd0, 1, 0, 0);
    apply_stimulus(OPCODE_LOAD, F3_H, 32'h0000_3006, 32'd0, 32'h8001_1234, 0, 2, 0);
    apply_stimulus(OPCODE_LOAD, F3_BU, 32'h0000_0001, 32'd0, 32'h0000_FF00, 1, 0, 0);
    apply_stimulus(OPCODE_STORE, F3_W, 32'h0000_4000, 32'hDEAD_BEEF, 32'd0, 2, 0, 0);
    apply_stimulus(OPCODE_LOAD, 3'b011, 32'h0000_0008, 32'd0, 32'hFFFF_FFFF, 0, 0, 0);
    apply_stimulus(OPCODE_LOAD, F3_H, 32'h0000_3007, 32'd0, 32'h8001_1234, 0, 0, 0);
    apply_stimulus(OPCODE_STORE, 3'b111, 32'h0000_0010, 32'h0BAD_0BAD, 32'd0, 0, 0, 0);
    apply_stimulus(OPCODE_STORE, F3_BU, 32'h0000_0010, 32'h0BAD_0BAD, 32'd0, 0, 0, 0);

    valid = 1; opcode = 7'b0110011; funct3 = F3_W; address = 32'h20;
    @(negedge clk);
    valid = 0;
    repeat (2) @(negedge clk);

    reset_test();
    apply_stimulus(OPCODE_LOAD, F3_W, 32'h0000_0020, 32'd0, 32'h0102_0304, 0, 0, 0);
    check_output("recover_literal", load_data, 32'h0102_0304);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
